dp_wb_writeback_stage: RTL and testbench

//  Writeback stage fed by the EX/WB pipeline register. Selects the register-file write data
//  (ALU result, load data, PC+4 or BNN popcount) and drives register-file write port 3.

---
 rtl/dp_wb_writeback_stage.sv | 96 +++++++++
 tb/tb_dp_wb_writeback_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dp_wb_writeback_stage.sv
// dp_wb_writeback_stage: register-file write port driver with an iterative, stalling popcount path
module dp_wb_writeback_stage #(
    parameter int XLEN    = 32,
    parameter int CHUNK_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            FlushW,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [4:0]      A3_W,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCNextW,
    input  logic [XLEN-1:0] length_adjusted_W,
    output logic            WE3,
    output logic [4:0]      A3,
    output logic [XLEN-1:0] WD3,
    output logic            StallW,
    output logic            busy
);
    localparam int N_ITER = XLEN / CHUNK_W;
    localparam int AW     = $clog2(XLEN + 1);
    localparam int IW     = N_ITER > 1 ? $clog2(N_ITER) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [4:0]        dest_q, dest_d;
    logic [AW-1:0]     acc_q, acc_d, chunk_cnt;
    logic [IW-1:0]     iter_q, iter_d;
    logic              pop_req;
    logic [XLEN-1:0]   mux_data;

    assign pop_req  = RegWriteW && ResultSrcW == 2'b11 && !FlushW;
    assign mux_data = ResultSrcW == 2'b00 ? ALUResultW :
                      ResultSrcW == 2'b01 ? ReadDataW  :
                      ResultSrcW == 2'b10 ? PCNextW    : '0;

    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK_W; i++) chunk_cnt = chunk_cnt + AW'(opnd_q[i]);
    end

    // Flush suppresses the write and the stall in whatever state it lands
    always_comb begin
        WE3    = !FlushW && (state_q == DONE ? dest_q != 5'd0 :
                 state_q == IDLE && RegWriteW && ResultSrcW != 2'b11 && A3_W != 5'd0);
        A3     = state_q == IDLE ? A3_W : dest_q;
        WD3    = state_q == DONE ? {{(XLEN-AW){1'b0}}, acc_q} :
                 state_q == IDLE ? mux_data : '0;
        StallW = !FlushW && (state_q == COUNT || (state_q == IDLE && pop_req));
        busy   = state_q != IDLE;
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        dest_d  = dest_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        if (FlushW) begin
            state_d = IDLE;
        end else if (state_q == IDLE && pop_req) begin
            state_d = COUNT;
            opnd_d  = length_adjusted_W;
            dest_d  = A3_W;
            acc_d   = '0;
            iter_d  = '0;
        end else if (state_q == COUNT) begin
            acc_d   = acc_q + chunk_cnt;
            opnd_d  = opnd_q >> CHUNK_W;
            iter_d  = iter_q + IW'(1);
            state_d = iter_q == IW'(N_ITER - 1) ? DONE : COUNT;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            dest_q  <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            dest_q  <= dest_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
        end
    end
endmodule

// File: tb/tb_dp_wb_writeback_stage.sv
// tb_dp_wb_writeback_stage: directed and random stimulus against a transaction-level writeback model
module tb_dp_wb_writeback_stage;
    localparam int N_ITER = 4;

    logic        clk, reset_n, FlushW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  A3_W, A3;
    logic [31:0] ALUResultW, ReadDataW, PCNextW, length_adjusted_W, WD3;
    logic        WE3, StallW, busy;

    dp_wb_writeback_stage dut (
        .clk(clk), .reset_n(reset_n), .FlushW(FlushW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .A3_W(A3_W), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCNextW(PCNextW), .length_adjusted_W(length_adjusted_W),
        .WE3(WE3), .A3(A3), .WD3(WD3), .StallW(StallW), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks, n_pass;
    bit          m_pend;
    int          m_cnt;
    logic [31:0] m_val, last_wd;
    logic [4:0]  m_dest;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        FlushW = 0; RegWriteW = 0; ResultSrcW = 0; A3_W = 0;
        ALUResultW = 0; ReadDataW = 0; PCNextW = 0; length_adjusted_W = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic step(output bit stalled, output bit wrote);
        bit          req, e_we, e_st, e_busy;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        @(negedge clk);
        req  = RegWriteW && ResultSrcW == 2'b11 && !FlushW;
        e_a3 = 0;
        e_wd = 0;
        if (m_pend && m_cnt > 0) begin
            e_busy = 1; e_st = !FlushW; e_we = 0;
        end else if (m_pend) begin
            e_busy = 1; e_st = 0; e_we = !FlushW && m_dest != 0; e_a3 = m_dest; e_wd = m_val;
        end else begin
            e_busy = 0; e_st = req;
            e_we = !FlushW && RegWriteW && ResultSrcW != 2'b11 && A3_W != 0;
            e_a3 = A3_W;
            e_wd = ResultSrcW == 2'b00 ? ALUResultW : ResultSrcW == 2'b01 ? ReadDataW : PCNextW;
        end
        check("we3", 32'(WE3), 32'(e_we));
        check("stall", 32'(StallW), 32'(e_st));
        check("busy", 32'(busy), 32'(e_busy));
        if (e_we) begin
            check("a3", 32'(A3), 32'(e_a3));
            check("wd3", WD3, e_wd);
            last_wd = WD3;
        end
        stalled = e_st;
        wrote   = e_we;
        @(posedge clk);
        if (FlushW) m_pend = 0;
        else if (!m_pend && req) begin
            m_pend = 1; m_cnt = N_ITER; m_val = $countones(length_adjusted_W); m_dest = A3_W;
        end else if (m_pend && m_cnt > 0) m_cnt--;
        else if (m_pend) m_pend = 0;
        #1;
    endtask

    // Present one instruction and hold it while the stage stalls, like the EX/WB register would
    task automatic issue(input bit rw, input logic [1:0] src, input logic [4:0] a3,
                         input logic [31:0] val, input int flush_at,
                         output int stalls, output int writes);
        bit st, wr, done;
        stalls = 0; writes = 0; done = 0;
        RegWriteW = rw; ResultSrcW = src; A3_W = a3;
        ALUResultW = $urandom; ReadDataW = $urandom; PCNextW = $urandom; length_adjusted_W = $urandom;
        case (src)
            2'b00: ALUResultW = val;
            2'b01: ReadDataW = val;
            2'b10: PCNextW = val;
            default: length_adjusted_W = val;
        endcase
        for (int k = 0; k < 16 && !done; k++) begin
            FlushW = (k == flush_at);
            step(st, wr);
            stalls += int'(st);
            writes += int'(wr);
            done = !st || FlushW;
        end
        if (!done) check("stall_bound", 32'(StallW), 32'd0);
        FlushW = 0;
    endtask

    initial begin
        int st, wr;
        bit s1, w1;
        n_checks = 0; n_pass = 0; m_pend = 0; m_cnt = 0; last_wd = 0;
        clear_inputs();
        reset_n = 0;
        #2;
        check("rst_we3", 32'(WE3), 0);
        check("rst_a3", 32'(A3), 0);
        check("rst_wd3", WD3, 0);
        check("rst_stall", 32'(StallW), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        issue(1, 2'b00, 5'd5, 32'h1234, -1, st, wr);
        check("t1_stalls", st, 0); check("t1_writes", wr, 1); check("t1_wd", last_wd, 32'h1234);

        issue(1, 2'b11, 5'd7, 32'hFFFF_FFFF, -1, st, wr);
        check("t2_stalls", st, 5); check("t2_writes", wr, 1); check("t2_wd", last_wd, 32);
        issue(1, 2'b11, 5'd7, 32'h0, -1, st, wr);
        check("t2z_writes", wr, 1); check("t2z_wd", last_wd, 0);

        issue(1, 2'b11, 5'd3, 32'h8000_0001, -1, st, wr);
        check("t3a_stalls", st, 5); check("t3a_wd", last_wd, 2);
        issue(1, 2'b11, 5'd4, 32'h0000_00FF, -1, st, wr);
        check("t3b_stalls", st, 5); check("t3b_wd", last_wd, 8);

        issue(1, 2'b11, 5'd0, 32'hDEAD_BEEF, -1, st, wr);
        check("t4_stalls", st, 5); check("t4_writes", wr, 0);

        issue(1, 2'b11, 5'd9, 32'hFFFF_0000, 2, st, wr);
        check("t5_writes", wr, 0);
        issue(1, 2'b00, 5'd10, 32'hCAFE_0001, -1, st, wr);
        check("t5_alu_writes", wr, 1); check("t5_alu_wd", last_wd, 32'hCAFE_0001);

        RegWriteW = 1; ResultSrcW = 2'b11; A3_W = 5'd12; length_adjusted_W = 32'hF0F0_F0F0;
        step(s1, w1);
        step(s1, w1);
        reset_n = 0;
        clear_inputs();
        m_pend = 0; m_cnt = 0;
        #1;
        check("t6_we3", 32'(WE3), 0);
        check("t6_wd3", WD3, 0);
        check("t6_stall", 32'(StallW), 0);
        check("t6_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        issue(1, 2'b10, 5'd11, 32'h104, -1, st, wr);
        check("t6_pc_writes", wr, 1); check("t6_pc_wd", last_wd, 32'h104);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] v;
            v = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0) : $urandom;
            issue($urandom_range(0, 7) != 0, 2'($urandom), $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom),
                  v, $urandom_range(0, 15) == 0 ? int'($urandom_range(0, 6)) : -1, st, wr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
